button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
- Multi-channel debouncer and edge detector for raw push-button/switch inputs.
- Downstream consumer of the clock-divider's 1 kHz sample tick: samples each synchronised input only on tick_in and commits a new level after STABLE_TICKS consecutive agreeing samples.
- Emits clean levels plus single-clk_in rise/fall pulses that feed the Moore sequence FSM.

Parameters:
- WIDTH, 4, number of independent input channels (1..16).
- STABLE_TICKS, 20, consecutive agreeing tick samples required to commit a level change (legal 2..255; 20 ms at 1 kHz).
- CNT_W, 8, width of the per-channel stability counter; must satisfy 2^CNT_W > STABLE_TICKS.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst_in  input  1  synchronous, active-high reset.
- tick_in  input  1  sample strobe, one clk_in wide (driven by divider tick_mf).
- btn_in  input  WIDTH  raw asynchronous button levels.
- level_out  output  WIDTH  debounced level per channel.
- rise_out  output  WIDTH  one-clk_in pulse when a channel commits 0->1.
- fall_out  output  WIDTH  one-clk_in pulse when a channel commits 1->0.

Behaviour:
- Reset (rst_in high at posedge): sync flops, counters, level_out, rise_out, fall_out all 0; every channel state STABLE_LO. Reset overrides all other activity, including mid-count and on tick cycles.
- Synchroniser: 2-FF per bit on clk_in; s = second stage. No other logic uses btn_in directly.
- Cycles with tick_in=0: state, counter and level_out hold; rise_out/fall_out forced 0.
- Per-channel Moore FSM, evaluated only when tick_in=1:
  - STABLE_LO: s=1 -> WAIT_HI, cnt<=1; else stay, cnt<=0.
  - WAIT_HI: s=0 -> STABLE_LO, cnt<=0; s=1 and cnt==STABLE_TICKS-1 -> STABLE_HI, cnt<=0, level_out<=1, rise_out<=1; s=1 otherwise -> cnt<=cnt+1.
  - STABLE_HI / WAIT_LO: mirror image with polarity inverted; commit sets level_out<=0, fall_out<=1.
- Pulses are registered, high for exactly the clk_in cycle after the committing tick edge, then cleared. There is never a rise and fall in the same cycle on one channel.
- Latency: btn_in step reaches s after 2 clk_in edges. level_out changes on the edge of the STABLE_TICKS-th consecutive tick that samples the new value.
- Glitch shorter than STABLE_TICKS ticks: no level change, no pulse; counter returns to 0.
- Back-to-back tick_in (consecutive cycles): each counts as a sample; no rate checking.
- Channels are fully independent; simultaneous commits on several channels are allowed.
- Counter never wraps: max value reached is STABLE_TICKS-1.

Decomposition:
- Shared package/header debounce_pkg: state encodings STABLE_LO=2'd0, WAIT_HI=2'd1, STABLE_HI=2'd2, WAIT_LO=2'd3.
- One sub-module, debounce_channel: single-bit synchroniser, FSM, counter and pulse registers. The top instantiates WIDTH copies via generate.

Test Plan:
- Reset: hold rst_in 3 cycles with btn_in=4'hF -> all outputs 0; release, toggle tick_in every 10 clk -> level_out reaches 4'hF after 20 ticks, rise_out=4'hF for exactly one cycle.
- Clean press ch0 with STABLE_TICKS=4 and tick every 10 clk -> level_out[0]=1 on the 4th tick after sync, rise_out[0] one cycle; release -> fall_out[0] after 4 ticks.
- Bounce ch1: high for 3 ticks, low 1, high 5 -> no commit until the 4th consecutive high tick of the final run; exactly one rise_out[1].
- tick_in held 0 for 1000 cycles with btn_in toggling -> level_out, rise_out and fall_out unchanged.
- Reset asserted while ch2 is in WAIT_HI with cnt=2 -> level_out[2]=0, no pulse; after release, a full STABLE_TICKS is required again.
- Simultaneous press ch0 and ch3 on the same cycle -> rise_out=4'b1001 in a single cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared encodings for the per-channel debounce FSM.
// Kept as plain localparams so older 2-bit state consumers can reuse them unchanged.
package debounce_pkg;

   localparam logic [1:0] STABLE_LO = 2'd0;
   localparam logic [1:0] WAIT_HI   = 2'd1;
   localparam logic [1:0] STABLE_HI = 2'd2;
   localparam logic [1:0] WAIT_LO   = 2'd3;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: 2-FF synchroniser, tick-qualified stability FSM/counter,
// registered level and one-cycle rise/fall pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = 20,
   parameter int unsigned CNT_W        = 8
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic tick_in,
   input  logic btn_in,
   output logic level_out,
   output logic rise_out,
   output logic fall_out
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_TICKS - 1);

   logic             sync1_q;
   logic             s_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // Pulses default low so they last exactly one cycle after a committing tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (tick_in) begin
         case (state_q)
            STABLE_LO: begin
               if (s_q) begin
                  state_d = WAIT_HI;
                  cnt_d   = CNT_W'(1);
               end else begin
                  cnt_d = '0;
               end
            end
            WAIT_HI: begin
               if (!s_q) begin
                  state_d = STABLE_LO;
                  cnt_d   = '0;
               end else if (cnt_q == LastCnt) begin
                  state_d = STABLE_HI;
                  cnt_d   = '0;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            STABLE_HI: begin
               if (!s_q) begin
                  state_d = WAIT_LO;
                  cnt_d   = CNT_W'(1);
               end else begin
                  cnt_d = '0;
               end
            end
            WAIT_LO: begin
               if (s_q) begin
                  state_d = STABLE_HI;
                  cnt_d   = '0;
               end else if (cnt_q == LastCnt) begin
                  state_d = STABLE_LO;
                  cnt_d   = '0;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         s_q     <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_out = level_q;
   assign rise_out  = rise_q;
   assign fall_out  = fall_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: WIDTH independent debounce_channel instances
// sharing the sample tick.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned STABLE_TICKS = 20,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             tick_in,
   input  logic [WIDTH-1:0] btn_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise_out,
   output logic [WIDTH-1:0] fall_out
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      debounce_channel #(
         .STABLE_TICKS(STABLE_TICKS),
         .CNT_W       (CNT_W)
      ) u_chan (
         .clk_in   (clk_in),
         .rst_in   (rst_in),
         .tick_in  (tick_in),
         .btn_in   (btn_in[i]),
         .level_out(level_out[i]),
         .rise_out (rise_out[i]),
         .fall_out (fall_out[i])
      );
   end

endmodule
